// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the N-to-1 stream multiplexer.
// The LOCKED state type is used only when STREAM_MUX_PKT_LOCK_EN is defined.
package stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int DEF_N_CH  = 4;
   localparam int DEF_WIDTH = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to 0.
// ptr is assumed to be a legal channel index (below N_CH).
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int SW   = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [SW-1:0]   ptr,
   output logic [SW-1:0]   gnt_idx,
   output logic            gnt_any
);

   localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);

   logic [SW-1:0] cand;

   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = ptr;
      for (int i = 0; i < N_CH; i++) begin
         if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
         cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
      end
   end

endmodule

// File: rtl/n_to_one_stream_mux.sv
// N-to-1 valid/ready stream mux with fixed-select and round-robin modes and a registered output.
// Defining STREAM_MUX_PKT_LOCK_EN adds in_last/y_last and holds a round-robin grant for a whole packet.
module n_to_one_stream_mux
   import stream_mux_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int WIDTH = DEF_WIDTH,
   parameter int SW    = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SW-1:0]         s,
   output logic [WIDTH-1:0]      y,
   output logic                  y_valid,
   input  logic                  y_ready,
   output logic [SW-1:0]         y_ch
`ifdef STREAM_MUX_PKT_LOCK_EN
   ,
   input  logic [N_CH-1:0]       in_last,
   output logic                  y_last
`endif
);

   // Handshake: a beat moves on valid && ready; the output register reloads when empty or draining.
   localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);
   localparam logic [SW:0]   N_CH_W  = (SW + 1)'(N_CH);

   logic          load_ok;
   logic          xfer;
   logic          rr_path;
   logic          grant_en;
   logic          arb_any;
   logic          ptr_adv;
   logic [SW-1:0] grant;
   logic [SW-1:0] arb_idx;
   logic [SW-1:0] rr_ptr;

`ifdef STREAM_MUX_PKT_LOCK_EN
   lock_state_t   state;
   lock_state_t   state_nxt;
   logic [SW-1:0] lock_ch;
`endif

   rr_arbiter #(.N_CH(N_CH), .SW(SW)) u_arb (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   assign load_ok = !y_valid || y_ready;

   always_comb begin
      grant    = '0;
      grant_en = 1'b0;
      rr_path  = 1'b0;
      if (mode == MODE_RR) begin
         grant    = arb_idx;
         grant_en = arb_any;
         rr_path  = 1'b1;
      end else begin
         grant    = s;
         grant_en = ({1'b0, s} < N_CH_W);
      end
`ifdef STREAM_MUX_PKT_LOCK_EN
      // A locked packet overrides mode and holds the channel even through valid gaps.
      if (state == LOCKED) begin
         grant    = lock_ch;
         grant_en = 1'b1;
         rr_path  = 1'b1;
      end
`endif
   end

   always_comb begin
      in_ready = '0;
      if (grant_en && !rst) in_ready[grant] = load_ok;
   end

   assign xfer = grant_en && load_ok && in_valid[grant];

`ifdef STREAM_MUX_PKT_LOCK_EN
   assign ptr_adv = xfer && rr_path && in_last[grant];
`else
   assign ptr_adv = xfer && rr_path;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y       <= '0;
         y_ch    <= '0;
         y_valid <= 1'b0;
      end else if (xfer) begin
         y       <= in_data[grant*WIDTH +: WIDTH];
         y_ch    <= grant;
         y_valid <= 1'b1;
      end else if (y_ready) begin
         y_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rr_ptr <= '0;
      else if (ptr_adv) rr_ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       y_last <= 1'b0;
      else if (xfer) y_last <= in_last[grant];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lock_ch <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == LOCKED) lock_ch <= grant;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer && rr_path && !in_last[grant]) state_nxt = LOCKED;
         LOCKED:  if (xfer && in_last[grant])             state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
`endif

endmodule

// File: tb/tb_n_to_one_stream_mux.sv
// Directed bench for n_to_one_stream_mux: expected beats are queued at stimulus time and
// popped by a monitor whenever an output beat leaves; direct checks cover reset and stalls.
module tb_n_to_one_stream_mux;
   import stream_mux_pkg::*;

   localparam int N_CH  = 4;
   localparam int WIDTH = 8;
   localparam int SW    = 2;
   localparam int W     = 1 + SW + WIDTH;

   logic                  clk;
   logic                  rst;
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_ready;
   logic                  mode;
   logic [SW-1:0]         s;
   logic [WIDTH-1:0]      y;
   logic                  y_valid;
   logic                  y_ready;
   logic [SW-1:0]         y_ch;
   logic                  y_last_s;

   logic [W-1:0] exp_q[$];
   int total;
   int bad;

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic [N_CH-1:0] in_last;
   logic            y_last;
   assign y_last_s = y_last;
`else
   assign y_last_s = 1'b0;
`endif

   n_to_one_stream_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mode     (mode),
      .s        (s),
      .y        (y),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y_ch     (y_ch)
`ifdef STREAM_MUX_PKT_LOCK_EN
      ,
      .in_last  (in_last),
      .y_last   (y_last)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // driver helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic last, input logic [SW-1:0] ch, input logic [WIDTH-1:0] d);
      exp_q.push_back({last, ch, d});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // scoreboard monitor: a beat leaves at the next edge when y_valid && y_ready
   always @(negedge clk) begin
      if (!rst && y_valid && y_ready) begin
         logic [W-1:0] e;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected: got ch=%0d y=%0h want none", y_ch, y);
         end else begin
            e = exp_q.pop_front();
            if ({y_last_s, y_ch, y} !== e) begin
               bad++;
               $display("FAIL beat: got last=%0b ch=%0d y=%0h want last=%0b ch=%0d y=%0h",
                        y_last_s, y_ch, y, e[W-1], e[W-2 -: SW], e[WIDTH-1:0]);
            end
         end
      end
   end

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      in_data  = '0;
      in_valid = '0;
      mode     = MODE_FIXED;
      s        = '0;
      y_ready  = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      in_last  = '0;
`endif

      // reset state
      #3;
      check("rst_y_valid", 32'(y_valid), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_y_ch", 32'(y_ch), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // fixed select, ch2
      mode     = MODE_FIXED;
      s        = 2'd2;
      in_data  = {8'hD3, 8'hA5, 8'hB1, 8'hC0};
      in_valid = 4'b0100;
      y_ready  = 1'b1;
      push(1'b0, 2'd2, 8'hA5);
      @(negedge clk);
      check("fixed_in_ready", 32'(in_ready), 32'b0100);
      tick();
      in_valid = '0;
      @(negedge clk);
      check("fixed_y_valid", 32'(y_valid), 32'd1);
      tick();
      @(negedge clk);
      check("drain_y_valid", 32'(y_valid), 32'd0);
      tick();

      // round robin, all valid, pointer starts at 0
      mode     = MODE_RR;
      in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      in_valid = 4'b1111;
      push(1'b0, 2'd0, 8'h10);
      push(1'b0, 2'd1, 8'h11);
      push(1'b0, 2'd2, 8'h12);
      push(1'b0, 2'd3, 8'h13);
      push(1'b0, 2'd0, 8'h10);
      push(1'b0, 2'd1, 8'h11);
      @(negedge clk);
      check("rr_in_ready", 32'(in_ready), 32'b0001);
      repeat (6) tick();
      in_valid = '0;
      tick();

      // skip and wrap: pointer 2 -> grant 2 -> pointer 3 -> grant 1 -> pointer 2
      in_data  = {8'h23, 8'h22, 8'h21, 8'h20};
      in_valid = 4'b0100;
      push(1'b0, 2'd2, 8'h22);
      tick();
      in_valid = 4'b0010;
      push(1'b0, 2'd1, 8'h21);
      @(negedge clk);
      check("wrap_in_ready", 32'(in_ready), 32'b0010);
      tick();
      in_valid = 4'b1111;
      push(1'b0, 2'd2, 8'h22);
      @(negedge clk);
      check("ptr_after_wrap", 32'(in_ready), 32'b0100);
      tick();
      in_valid = '0;
      tick();

      // back-pressure: held beat stays put while s, data and mode move
      mode     = MODE_FIXED;
      s        = 2'd0;
      in_data  = {8'h93, 8'h92, 8'h91, 8'h5C};
      in_valid = 4'b0001;
      y_ready  = 1'b0;
      push(1'b0, 2'd0, 8'h5C);
      tick();
      for (int i = 0; i < 3; i++) begin
         s        = 2'(i + 1);
         in_data  = ~in_data;
         in_valid = 4'b1111;
         mode     = (i % 2 == 0) ? MODE_RR : MODE_FIXED;
         @(negedge clk);
         check("stall_y", 32'(y), 32'h5C);
         check("stall_y_ch", 32'(y_ch), 32'd0);
         check("stall_y_valid", 32'(y_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = '0;
      mode     = MODE_FIXED;
      y_ready  = 1'b1;
      tick();
      tick();

      // asynchronous reset discards a held beat; pointer (now 3) returns to 0
      s        = 2'd3;
      in_data  = {8'h77, 8'h66, 8'h55, 8'h44};
      in_valid = 4'b1000;
      y_ready  = 1'b0;
      tick();
      mode     = MODE_RR;
      in_valid = 4'b1111;
      #2;
      rst = 1'b1;
      #1;
      check("arst_y_valid", 32'(y_valid), 32'd0);
      check("arst_y", 32'(y), 32'd0);
      check("arst_y_ch", 32'(y_ch), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst      = 1'b0;
      in_data  = {8'h83, 8'h82, 8'h81, 8'h80};
      in_valid = 4'b1010;
      y_ready  = 1'b1;
      push(1'b0, 2'd1, 8'h81);
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'b0010);
      tick();
      in_valid = '0;
      tick();

`ifdef STREAM_MUX_PKT_LOCK_EN
      // packet lock: ch1 keeps the grant for 3 beats while ch2 waits
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      mode     = MODE_RR;
      y_ready  = 1'b1;
      in_valid = 4'b0110;
      in_last  = 4'b0000;
      in_data  = {8'h43, 8'h42, 8'hA1, 8'h40};
      push(1'b0, 2'd1, 8'hA1);
      tick();
      in_data[15:8] = 8'hA2;
      push(1'b0, 2'd1, 8'hA2);
      tick();
      in_data[15:8] = 8'hA3;
      in_last = 4'b0010;
      push(1'b1, 2'd1, 8'hA3);
      tick();
      in_last = 4'b0100;
      push(1'b1, 2'd2, 8'h42);
      tick();
      in_valid = '0;
      in_last  = '0;
      tick();
`endif

      tick();
      tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/n_to_one_stream_mux.md
N_TO_ONE_STREAM_MUX -- requirements
Module: n_to_one_stream_mux

Interface
REQ-001 Parameter N_CH, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter WIDTH, default 8: data bits per channel; legal range >= 1.
REQ-003 Parameter SW, default $clog2(N_CH): select/channel-index width; derived, not overridden.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_data  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  in  N_CH  per-channel data-valid.
REQ-008 in_ready  out  N_CH  per-channel accept; a beat transfers on in_valid[k] && in_ready[k].
REQ-009 mode  in  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR).
REQ-010 s  in  SW  channel select, used in MODE_FIXED only.
REQ-011 y  out  WIDTH  registered output data.
REQ-012 y_valid  out  1  output holds a beat.
REQ-013 y_ready  in  1  downstream accept; a beat leaves on y_valid && y_ready.
REQ-014 y_ch  out  SW  index of the channel that supplied y.

Function
REQ-015 The output register shall be loadable when load_ok = !y_valid || y_ready.
REQ-016 At most one in_ready bit shall be high in any cycle.
REQ-017 MODE_FIXED: in_ready[s] = load_ok; all other in_ready bits = 0.
REQ-018 MODE_FIXED with s >= N_CH: all in_ready = 0 and no load occurs.
REQ-019 MODE_RR: grant = first k with in_valid[k] set, scanning from rr_ptr upward and wrapping past N_CH-1 to 0; in_ready[grant] = load_ok.
REQ-020 After an MODE_RR transfer from grant g, rr_ptr shall become (g+1) mod N_CH; otherwise rr_ptr holds.
REQ-021 On transfer, y, y_ch and y_valid shall update on the next edge: one-cycle latency, with a full beat per cycle sustained when y_ready = 1.
REQ-022 With y_valid = 1 and y_ready = 0, y and y_ch shall remain stable regardless of in_*, s or mode.
REQ-023 If no load occurs and the output beat leaves, y_valid shall fall to 0 on the next edge.
REQ-024 A change of mode or s shall affect only the next grant decision; it shall not alter rr_ptr or a held output beat.

Reset
REQ-025 While rst = 1: y_valid = 0, y = 0, y_ch = 0, rr_ptr = 0 and in_ready = 0, asynchronously.
REQ-026 Reset asserted mid-transfer shall discard the held beat; the first grant after release shall start scanning at channel 0.

Configuration
REQ-027 Macro STREAM_MUX_PKT_LOCK_EN shall add ports in_last (in, N_CH) and y_last (out, 1, registered alongside y, reset 0).
REQ-028 With the macro defined, MODE_RR shall use a two-state FSM, IDLE -> LOCKED on a transfer with in_last = 0, and LOCKED -> IDLE on a transfer with in_last = 1.
REQ-029 In LOCKED, the grant shall stay on the locked channel even while it is not valid, and rr_ptr shall advance only on the last beat.
REQ-030 A mode change while in LOCKED shall take effect only after the lock releases.
REQ-031 Without the macro, MODE_RR shall arbitrate per beat and the FSM, in_last and y_last shall not exist.

Structure
REQ-032 Package stream_mux_pkg shall hold: mode constants MODE_FIXED and MODE_RR; default N_CH and WIDTH; FSM state type {IDLE, LOCKED}.
REQ-033 Round-robin selection shall be a sub-module rr_arbiter (inputs req[N_CH] and ptr[SW]; outputs gnt_idx[SW] and gnt_any), which is purely combinational.

Verification
REQ-034 Fixed path: MODE_FIXED, s=2, in_data ch2=8'hA5, in_valid=4'b0100, y_ready=1 -> next cycle y=8'hA5, y_ch=2, y_valid=1.
REQ-035 Round-robin: MODE_RR, all channels valid, y_ready=1 for 6 cycles -> y_ch sequence 0,1,2,3,0,1.
REQ-036 Back-pressure: y_valid=1, y_ready=0 for 3 cycles while s and in_data toggle -> y and y_ch are unchanged and all in_ready=0.
REQ-037 Skip and wrap: MODE_RR, rr_ptr=3, in_valid=4'b0010 -> grant=1 and rr_ptr becomes 2.
REQ-038 Async reset: assert rst mid-cycle with y_valid=1 -> y_valid=0 and y=0 immediately, without waiting for a clock edge; after release, the first RR grant is the lowest valid channel from 0.
REQ-039 STREAM_MUX_PKT_LOCK_EN: ch1 sends 3 beats (last on the 3rd) while ch2 is valid throughout -> y_ch=1,1,1, then 2; y_last=1 on the 3rd beat only.
